// File: rtl/memory_x_sched.sv
// memory_x_sched: walks the LSTM input-vector memory one timestep at a time,
// forward or reverse, across NSEQ back-to-back sequences. Each vector is
// offered with x_valid/x_ready and the walk waits for step_done before moving on.
module memory_x_sched #(
  parameter  int WIDTH    = 32,
  parameter  int NUM      = 53,
  parameter  int TIMESTEP = 7,
  parameter  int NSEQ     = 2,
  localparam int TW       = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1,
  localparam int SW       = (NSEQ > 1) ? $clog2(NSEQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rev,
  input  logic             abort,
  input  logic             x_ready,
  input  logic             step_done,
  output logic [WIDTH-1:0] addr,
  output logic             x_valid,
  output logic [TW-1:0]    t_idx,
  output logic [SW-1:0]    seq_idx,
  output logic             first_step,
  output logic             last_step,
  output logic             busy,
  output logic             done
);

  localparam logic [TW-1:0]    T_LAST   = TW'(TIMESTEP - 1);
  localparam logic [TW-1:0]    T_PENULT = TW'((TIMESTEP > 1) ? TIMESTEP - 2 : 0);
  localparam logic [TW-1:0]    T_ONE    = TW'(1);
  localparam logic [SW-1:0]    SEQ_LAST = SW'(NSEQ - 1);
  localparam logic [WIDTH-1:0] A_NUM    = WIDTH'(NUM);
  localparam logic [WIDTH-1:0] A_REV0   = WIDTH'((TIMESTEP - 1) * NUM);
  // Reverse walk ends a sequence at its base (t=0); the next sequence starts at
  // its own t=TIMESTEP-1, which is (2*TIMESTEP-1) strides further on.
  localparam logic [WIDTH-1:0] A_JUMP_R = WIDTH'((2 * TIMESTEP - 1) * NUM);
  localparam logic             ONE_STEP = (TIMESTEP == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_OFFER,
    S_WAIT,
    S_FIN
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic             w_start_run;
  logic             w_advance;

  logic             r_rev;
  logic [WIDTH-1:0] r_addr;
  logic [TW-1:0]    r_t;
  logic [SW-1:0]    r_seq;
  logic             r_first;
  logic             r_last;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state decode; abort overrides every other input.
  always_comb begin
    w_state_nx  = r_state;
    w_start_run = 1'b0;
    w_advance   = 1'b0;
    if (abort) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nx  = S_LOAD;
            w_start_run = 1'b1;
          end
        end
        S_LOAD:  w_state_nx = S_OFFER;
        S_OFFER: if (x_ready) w_state_nx = S_WAIT;
        S_WAIT: begin
          if (step_done) begin
            if (r_last && (r_seq == SEQ_LAST)) begin
              w_state_nx = S_FIN;
            end else begin
              w_state_nx = S_LOAD;
              w_advance  = 1'b1;
            end
          end
        end
        S_FIN:   w_state_nx = S_IDLE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Address/index datapath: running adders step by one stride per timestep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rev   <= 1'b0;
      r_addr  <= '0;
      r_t     <= '0;
      r_seq   <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_start_run) begin
      r_rev   <= rev;
      r_seq   <= '0;
      r_t     <= rev ? T_LAST : '0;
      r_addr  <= rev ? A_REV0 : '0;
      r_first <= 1'b1;
      r_last  <= ONE_STEP;
    end else if (w_advance) begin
      if (r_last) begin
        r_seq   <= r_seq + SW'(1);
        r_first <= 1'b1;
        r_last  <= ONE_STEP;
        if (r_rev) begin
          r_t    <= T_LAST;
          r_addr <= r_addr + A_JUMP_R;
        end else begin
          r_t    <= '0;
          r_addr <= r_addr + A_NUM;
        end
      end else begin
        r_first <= 1'b0;
        if (r_rev) begin
          r_t    <= r_t - T_ONE;
          r_addr <= r_addr - A_NUM;
          r_last <= (r_t == T_ONE);
        end else begin
          r_t    <= r_t + T_ONE;
          r_addr <= r_addr + A_NUM;
          r_last <= (r_t == T_PENULT);
        end
      end
    end
  end

  assign addr       = r_addr;
  assign t_idx      = r_t;
  assign seq_idx    = r_seq;
  assign first_step = r_first;
  assign last_step  = r_last;
  assign x_valid    = (r_state == S_OFFER);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_FIN);

endmodule

// File: tb/tb_memory_x_sched.sv
// Directed bench for memory_x_sched with default parameters (NUM=53, TIMESTEP=7, NSEQ=2).
module tb_memory_x_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, rev, abort, x_ready, step_done;
  logic [31:0] addr;
  logic        x_valid;
  logic [2:0]  t_idx;
  logic [0:0]  seq_idx;
  logic        first_step, last_step, busy, done;

  int total = 0;
  int bad   = 0;

  memory_x_sched #(.WIDTH(32), .NUM(53), .TIMESTEP(7), .NSEQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rev       (rev),
    .abort     (abort),
    .x_ready   (x_ready),
    .step_done (step_done),
    .addr      (addr),
    .x_valid   (x_valid),
    .t_idx     (t_idx),
    .seq_idx   (seq_idx),
    .first_step(first_step),
    .last_step (last_step),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full run with ready and step_done always high: 14 steps of LOAD/OFFER/WAIT then FIN.
  task automatic run_full(input logic r);
    int s, j, t;
    x_ready = 1'b1; step_done = 1'b1; rev = r; start = 1'b1;
    step();
    start = 1'b0; rev = 1'b0;
    for (int k = 0; k < 14; k++) begin
      s = k / 7;
      j = k % 7;
      t = r ? 6 - j : j;
      chk("run_load_xv", 32'(x_valid), 0);
      chk("run_load_busy", 32'(busy), 1);
      chk("run_load_done", 32'(done), 0);
      step();
      chk("run_offer_xv", 32'(x_valid), 1);
      chk("run_offer_addr", addr, 32'(s * 371 + t * 53));
      chk("run_offer_t", 32'(t_idx), 32'(t));
      chk("run_offer_seq", 32'(seq_idx), 32'(s));
      chk("run_offer_first", 32'(first_step), (j == 0) ? 1 : 0);
      chk("run_offer_last", 32'(last_step), (j == 6) ? 1 : 0);
      step();
      chk("run_wait_xv", 32'(x_valid), 0);
      chk("run_wait_done", 32'(done), 0);
      step();
    end
    chk("run_fin_done", 32'(done), 1);
    chk("run_fin_busy", 32'(busy), 1);
    chk("run_fin_xv", 32'(x_valid), 0);
    step();
    chk("run_idle_done", 32'(done), 0);
    chk("run_idle_busy", 32'(busy), 0);
    chk("run_idle_addr", addr, r ? 32'd371 : 32'd689);
    chk("run_idle_t", 32'(t_idx), r ? 0 : 6);
    chk("run_idle_seq", 32'(seq_idx), 1);
    x_ready = 1'b0; step_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rev = 1'b0; abort = 1'b0; x_ready = 1'b0; step_done = 1'b0;
    step();
    step();
    chk("rst_addr", addr, 0);
    chk("rst_t", 32'(t_idx), 0);
    chk("rst_seq", 32'(seq_idx), 0);
    chk("rst_xv", 32'(x_valid), 0);
    chk("rst_first", 32'(first_step), 0);
    chk("rst_last", 32'(last_step), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    step();

    // T1 forward, T2 reverse
    run_full(1'b0);
    step();
    run_full(1'b1);
    step();

    // T3 backpressure in OFFER
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_load_busy", 32'(busy), 1);
    chk("t3_load_first", 32'(first_step), 1);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_xv", 32'(x_valid), 1);
      chk("t3_hold_addr", addr, 0);
      step();
    end
    chk("t3_hold_xv_end", 32'(x_valid), 1);
    x_ready = 1'b1;
    step();
    x_ready = 1'b0;
    chk("t3_wait_xv", 32'(x_valid), 0);
    chk("t3_wait_busy", 32'(busy), 1);
    step();
    chk("t3_wait_hold_xv", 32'(x_valid), 0);
    chk("t3_wait_hold_addr", addr, 0);

    // T4 step_done outside WAIT is ignored
    step_done = 1'b1;
    step();
    chk("t4_load_addr", addr, 53);
    chk("t4_load_t", 32'(t_idx), 1);
    chk("t4_load_first", 32'(first_step), 0);
    step();
    chk("t4_offer_xv", 32'(x_valid), 1);
    chk("t4_offer_addr", addr, 53);
    step();
    chk("t4_offer2_xv", 32'(x_valid), 1);
    chk("t4_offer2_addr", addr, 53);
    chk("t4_offer2_t", 32'(t_idx), 1);
    step_done = 1'b0; x_ready = 1'b1;
    step();
    x_ready = 1'b0;
    chk("t4_wait_addr", addr, 53);
    chk("t4_wait_xv", 32'(x_valid), 0);

    // T5 abort in WAIT at t=3
    x_ready = 1'b1; step_done = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t5_wait_t", 32'(t_idx), 3);
    chk("t5_wait_addr", addr, 159);
    chk("t5_wait_xv", 32'(x_valid), 0);
    chk("t5_wait_busy", 32'(busy), 1);
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0; step_done = 1'b0; x_ready = 1'b0;
    chk("t5_abort_busy", 32'(busy), 0);
    chk("t5_abort_xv", 32'(x_valid), 0);
    chk("t5_abort_done", 32'(done), 0);
    chk("t5_abort_addr", addr, 159);
    chk("t5_abort_t", 32'(t_idx), 3);
    step();
    chk("t5_idle_done", 32'(done), 0);
    chk("t5_idle_busy", 32'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_restart_addr", addr, 0);
    chk("t5_restart_t", 32'(t_idx), 0);
    chk("t5_restart_first", 32'(first_step), 1);
    chk("t5_restart_busy", 32'(busy), 1);

    // T6 start while busy ignored, then async reset mid-OFFER
    x_ready = 1'b1; step_done = 1'b1;
    for (int i = 0; i < 4; i++) step();
    x_ready = 1'b0; step_done = 1'b0;
    chk("t6_offer_addr", addr, 53);
    chk("t6_offer_xv", 32'(x_valid), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_busy_start_addr", addr, 53);
    chk("t6_busy_start_t", 32'(t_idx), 1);
    chk("t6_busy_start_xv", 32'(x_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_addr", addr, 0);
    chk("t6_rst_t", 32'(t_idx), 0);
    chk("t6_rst_seq", 32'(seq_idx), 0);
    chk("t6_rst_xv", 32'(x_valid), 0);
    chk("t6_rst_first", 32'(first_step), 0);
    chk("t6_rst_last", 32'(last_step), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(done), 0);
    step();
    rst = 1'b0;
    step();
    chk("t6_post_busy", 32'(busy), 0);
    chk("t6_post_xv", 32'(x_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
